// File: rtl/alu_arb_pkg.sv
// Shared ALU op codes, data width and the request payload for the ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned ALU_W = 32;

  localparam logic [3:0] ALU_OP_ADD   = 4'b0000;
  localparam logic [3:0] ALU_OP_SUB   = 4'b0001;
  localparam logic [3:0] ALU_OP_SLL   = 4'b0010;
  localparam logic [3:0] ALU_OP_SRL   = 4'b0011;
  localparam logic [3:0] ALU_OP_SRA   = 4'b0100;
  localparam logic [3:0] ALU_OP_SLT   = 4'b0101;
  localparam logic [3:0] ALU_OP_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_OP_XOR   = 4'b0111;
  localparam logic [3:0] ALU_OP_OR    = 4'b1000;
  localparam logic [3:0] ALU_OP_AND   = 4'b1001;
  localparam logic [3:0] ALU_OP_PASSY = 4'b1010;
  localparam logic [3:0] ALU_OP_IDLE  = 4'b0000;

  typedef struct packed {
    logic [3:0]       op;
    logic [ALU_W-1:0] x;
    logic [ALU_W-1:0] y;
  } alu_req_t;

endpackage

// File: rtl/alu_arb_rr.sv
// Two-input grant generator: round-robin by default, fixed port-0 priority
// when ALU_ARB_FIXED_PRIO_EN is defined. Grants are suppressed during reset.
module alu_arb_rr (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  // No pointer state here; the clock only exists for a uniform interface.
  logic unused_clk;
  assign unused_clk = clk;

  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      if (eligible[0])      grant = 2'b01;
      else if (eligible[1]) grant = 2'b10;
    end
  end
`else
  logic prio_q;
  logic prio_d;

  // prio names the port that wins when both are eligible.
  always_comb begin
    grant  = 2'b00;
    prio_d = prio_q;
    if (!rst) begin
      case (eligible)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
      if (grant[0])      prio_d = 1'b1;
      else if (grant[1]) prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters and holds each port's result.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed port-0 priority.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned W = ALU_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [W-1:0] req0_x,
  input  logic [W-1:0] req0_y,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [W-1:0] req1_x,
  input  logic [W-1:0] req1_y,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_z,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_z,
  output logic [3:0]   alu_operation,
  output logic [W-1:0] alu_x,
  output logic [W-1:0] alu_y,
  input  logic [W-1:0] alu_z
);

  alu_req_t     req0_c, req1_c, sel_c;
  logic [1:0]   eligible_c, grant_c;
  logic         rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [W-1:0] rsp0_z_q, rsp0_z_d, rsp1_z_q, rsp1_z_d;

  assign req0_c = '{op: req0_op, x: ALU_W'(req0_x), y: ALU_W'(req0_y)};
  assign req1_c = '{op: req1_op, x: ALU_W'(req1_x), y: ALU_W'(req1_y)};

  // A response slot being drained this cycle counts as free.
  assign eligible_c[0] = req0_valid && (!rsp0_valid_q || rsp0_ready);
  assign eligible_c[1] = req1_valid && (!rsp1_valid_q || rsp1_ready);

  alu_arb_rr u_rr (
    .clk      (clk),
    .rst      (rst),
    .eligible (eligible_c),
    .grant    (grant_c)
  );

  always_comb begin
    sel_c = '{op: ALU_OP_IDLE, x: '0, y: '0};
    if (grant_c[0])      sel_c = req0_c;
    else if (grant_c[1]) sel_c = req1_c;
  end

  assign alu_operation = sel_c.op;
  assign alu_x         = W'(sel_c.x);
  assign alu_y         = W'(sel_c.y);
  assign req0_ready    = grant_c[0];
  assign req1_ready    = grant_c[1];

  // A new grant overrides a same-cycle drain so back-to-back issue keeps valid high.
  always_comb begin
    rsp0_valid_d = rsp0_valid_q;
    rsp0_z_d     = rsp0_z_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_z_d     = rsp1_z_q;
    if (grant_c[0]) begin
      rsp0_valid_d = 1'b1;
      rsp0_z_d     = alu_z;
    end else if (rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end
    if (grant_c[1]) begin
      rsp1_valid_d = 1'b1;
      rsp1_z_d     = alu_z;
    end else if (rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid_q <= 1'b0;
      rsp0_z_q     <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_z_q     <= '0;
    end else begin
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_z_q     <= rsp0_z_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_z_q     <= rsp1_z_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_z     = rsp0_z_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_z     = rsp1_z_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the alu_* ports.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_x, req0_y, req1_x, req1_y;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_z, rsp1_z;
  logic [3:0]  alu_operation;
  logic [31:0] alu_x, alu_y, alu_z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_x(req1_x), .req1_y(req1_y),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_z(rsp0_z),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_z(rsp1_z),
    .alu_operation(alu_operation), .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z)
  );

  // Behavioural ALU; unknown codes return 0.
  always_comb begin
    alu_z = 32'd0;
    case (alu_operation)
      ALU_OP_ADD:   alu_z = alu_x + alu_y;
      ALU_OP_SUB:   alu_z = alu_x - alu_y;
      ALU_OP_SLL:   alu_z = alu_x << alu_y[4:0];
      ALU_OP_SRL:   alu_z = alu_x >> alu_y[4:0];
      ALU_OP_SRA:   alu_z = 32'($signed(alu_x) >>> alu_y[4:0]);
      ALU_OP_SLT:   alu_z = {31'd0, $signed(alu_x) < $signed(alu_y)};
      ALU_OP_SLTU:  alu_z = {31'd0, alu_x < alu_y};
      ALU_OP_XOR:   alu_z = alu_x ^ alu_y;
      ALU_OP_OR:    alu_z = alu_x | alu_y;
      ALU_OP_AND:   alu_z = alu_x & alu_y;
      ALU_OP_PASSY: alu_z = alu_y;
      default:      alu_z = 32'd0;
    endcase
  end

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_op = 4'd0; req0_x = 32'd0; req0_y = 32'd0;
    req1_valid = 1'b0; req1_op = 4'd0; req1_x = 32'd0; req1_y = 32'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = ALU_OP_ADD; req0_x = 32'd5; req0_y = 32'd7;
    req1_valid = 1'b1; req1_op = ALU_OP_OR;  req1_x = 32'd3; req1_y = 32'd9;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b exp 00", {req0_ready, req1_ready});
    end
    checks++;
    if ({alu_operation, alu_x, alu_y} !== {4'd0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL reset_alu_idle got op=%h x=%h y=%h exp 0/0/0", alu_operation, alu_x, alu_y);
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp0_z, rsp1_z} !== {2'b00, 64'd0}) begin
      errors++; $display("FAIL reset_rsp got v=%b%b z0=%h z1=%h exp 00/0/0", rsp0_valid, rsp1_valid, rsp0_z, rsp1_z);
    end
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1'b1; req0_op = ALU_OP_ADD; req0_x = 32'd5; req0_y = 32'd7;
    rsp0_ready = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL single_grant got %b exp 10", {req0_ready, req1_ready});
    end
    checks++;
    if ({alu_operation, alu_x, alu_y} !== {ALU_OP_ADD, 32'd5, 32'd7}) begin
      errors++; $display("FAIL single_alu_drive got op=%h x=%h y=%h exp 0/5/7", alu_operation, alu_x, alu_y);
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp0_valid, rsp0_z} !== {1'b1, 32'd12}) begin
      errors++; $display("FAIL single_rsp got v=%b z=%h exp 1/0000000c", rsp0_valid, rsp0_z);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_contention();
    logic exp_g0;
    apply_reset();
    req0_valid = 1'b1; req0_op = ALU_OP_SUB; req0_x = 32'd10;   req0_y = 32'd3;
    req1_valid = 1'b1; req1_op = ALU_OP_XOR; req1_x = 32'hF0;   req1_y = 32'h0F;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g0 = 1'b1;
`else
      exp_g0 = (i % 2 == 0);
`endif
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== {exp_g0, ~exp_g0}) begin
        errors++; $display("FAIL contention_grant[%0d] got %b exp %b", i, {req0_ready, req1_ready}, {exp_g0, ~exp_g0});
      end
      @(posedge clk); #1;
      checks++;
      if (exp_g0 ? (rsp0_z !== 32'd7) : (rsp1_z !== 32'hFF)) begin
        errors++; $display("FAIL contention_result[%0d] got z0=%h z1=%h exp %s", i, rsp0_z, rsp1_z, exp_g0 ? "z0=7" : "z1=ff");
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_back_pressure();
    apply_reset();
    // Park a result on port 1 and hold it un-consumed.
    req1_valid = 1'b1; req1_op = ALU_OP_OR; req1_x = 32'h3; req1_y = 32'hC;
    @(posedge clk); #1;
    checks++;
    if ({rsp1_valid, rsp1_z} !== {1'b1, 32'hF}) begin
      errors++; $display("FAIL bp_park got v=%b z=%h exp 1/0000000f", rsp1_valid, rsp1_z);
    end
    @(negedge clk);
    req0_valid = 1'b1; req0_op = ALU_OP_ADD; req0_x = 32'd1; req0_y = 32'd1;
    rsp0_ready = 1'b1;
    req1_op = ALU_OP_PASSY; req1_x = 32'd0; req1_y = 32'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
        errors++; $display("FAIL bp_grant[%0d] got %b exp 10", i, {req0_ready, req1_ready});
      end
      @(posedge clk); #1;
      checks++;
      if ({rsp1_valid, rsp1_z, rsp0_z} !== {1'b1, 32'hF, 32'd2}) begin
        errors++; $display("FAIL bp_hold[%0d] got v1=%b z1=%h z0=%h exp 1/f/2", i, rsp1_valid, rsp1_z, rsp0_z);
      end
      @(negedge clk);
    end
    rsp1_ready = 1'b1;
    #1;
    checks++;
`ifdef ALU_ARB_FIXED_PRIO_EN
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL bp_release got %b exp 10", {req0_ready, req1_ready});
    end
`else
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_release got %b exp 01", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp1_valid, rsp1_z} !== {1'b1, 32'h55}) begin
      errors++; $display("FAIL bp_release_rsp got v=%b z=%h exp 1/00000055", rsp1_valid, rsp1_z);
    end
`endif
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_drain_refill();
    apply_reset();
    req0_valid = 1'b1; req0_op = ALU_OP_SLL; req0_x = 32'd1; req0_y = 32'd4;
    @(posedge clk); #1;
    checks++;
    if ({rsp0_valid, rsp0_z} !== {1'b1, 32'd16}) begin
      errors++; $display("FAIL refill_first got v=%b z=%h exp 1/00000010", rsp0_valid, rsp0_z);
    end
    @(negedge clk);
    req0_op = ALU_OP_SRA; req0_x = 32'h8000_0000; req0_y = 32'd4;
    rsp0_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL refill_grant got %b exp 1", req0_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp0_valid, rsp0_z} !== {1'b1, 32'hF800_0000}) begin
      errors++; $display("FAIL refill_second got v=%b z=%h exp 1/f8000000", rsp0_valid, rsp0_z);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rsp0_valid, rsp0_z} !== {1'b0, 32'hF800_0000}) begin
      errors++; $display("FAIL drain_clear got v=%b z=%h exp 0/f8000000", rsp0_valid, rsp0_z);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    // Port 0 grant moves the pointer to port 1 before reset.
    req0_valid = 1'b1; req0_op = ALU_OP_SLTU; req0_x = 32'd1; req0_y = 32'd2;
    @(posedge clk); #1;
    checks++;
    if ({rsp0_valid, rsp0_z} !== {1'b1, 32'd1}) begin
      errors++; $display("FAIL midrst_pending got v=%b z=%h exp 1/00000001", rsp0_valid, rsp0_z);
    end
    @(negedge clk);
    rst = 1'b1;
    req0_op = ALU_OP_ADD; req0_x = 32'd2; req0_y = 32'd3;
    req1_valid = 1'b1; req1_op = ALU_OP_ADD; req1_x = 32'd4; req1_y = 32'd4;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL midrst_ready got %b exp 00", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp0_valid, rsp0_z, rsp1_valid} !== {1'b0, 32'd0, 1'b0}) begin
      errors++; $display("FAIL midrst_clear got v0=%b z0=%h v1=%b exp 0/0/0", rsp0_valid, rsp0_z, rsp1_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL midrst_prio got %b exp 10", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp0_valid, rsp0_z} !== {1'b1, 32'd5}) begin
      errors++; $display("FAIL midrst_first got v=%b z=%h exp 1/00000005", rsp0_valid, rsp0_z);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_idle();
    // rsp0 holds 5 from the previous task; nobody consumes it.
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({alu_operation, alu_x, alu_y, req0_ready, req1_ready} !== {4'd0, 64'd0, 2'b00}) begin
        errors++; $display("FAIL idle_alu[%0d] got op=%h x=%h y=%h rdy=%b%b exp 0/0/0/00", i, alu_operation, alu_x, alu_y, req0_ready, req1_ready);
      end
      @(posedge clk); #1;
      checks++;
      if ({rsp0_valid, rsp0_z} !== {1'b1, 32'd5}) begin
        errors++; $display("FAIL idle_hold[%0d] got v=%b z=%h exp 1/00000005", i, rsp0_valid, rsp0_z);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_invalid_op();
    req1_valid = 1'b1; req1_op = 4'hF; req1_x = 32'h1234; req1_y = 32'h5678;
    rsp1_ready = 1'b1;
    #1;
    checks++;
    if ({req1_ready, alu_operation} !== {1'b1, 4'hF}) begin
      errors++; $display("FAIL invalid_op_drive got rdy=%b op=%h exp 1/f", req1_ready, alu_operation);
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp1_valid, rsp1_z} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL invalid_op_rsp got v=%b z=%h exp 1/00000000", rsp1_valid, rsp1_z);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_drain_refill();
    test_reset_mid();
    test_idle();
    test_invalid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit ALU between two requesters (for example the execute stage and a branch/address-generation unit) using valid/ready handshakes. Each cycle it grants at most one request, drives that request's operation and operands onto the ALU, and captures the ALU result into that requester's response register. Grants alternate round-robin when both requesters contend. The block sits directly in front of the ALU's `alu_operation`/`X`/`Y`/`Z` ports.

## Interface
- `W`, default 32: operand and result width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  grant; the request is accepted when `valid && ready`.
- `req0_op` / `req1_op`  in  4  ALU operation code, passed through unchanged.
- `req0_x`, `req0_y` / `req1_x`, `req1_y`  in  W  operands.
- `rsp0_valid` / `rsp1_valid`  out  1  a result is held for that requester.
- `rsp0_ready` / `rsp1_ready`  in  1  the requester consumes its result.
- `rsp0_z` / `rsp1_z`  out  W  registered result.
- `alu_operation`  out  4  drives the ALU's op input.
- `alu_x`, `alu_y`  out  W  drive the ALU's X/Y inputs.
- `alu_z`  in  W  ALU result (combinational from the ALU).

## Operation
- **Eligibility.** Port k is eligible when `reqk_valid && (!rspk_valid || rspk_ready)`. A response slot that is being drained this cycle counts as free.
- **Grant.** At most one `reqk_ready` is high per cycle.
  - Only one port eligible: that port is granted.
  - Both ports eligible: the port named by the priority pointer `prio` is granted.
  - Neither port eligible: no grant.
- **Pointer.** After a grant to port k, `prio` moves to the other port. With no grant, `prio` is unchanged.
- **ALU drive.** When port k is granted, `alu_operation`/`alu_x`/`alu_y` carry port k's op/x/y. With no grant, they carry the idle values: op 4'b0000, x = 0, y = 0.
- **Response capture.** On a grant to port k, at the clock edge `rspk_z <= alu_z` and `rspk_valid <= 1`.
- **Response clear.** If `rspk_valid && rspk_ready` and there is no new grant to port k, then `rspk_valid <= 0`. `rspk_z` holds its last value.
- **Same-cycle drain and grant.** If a port's response is drained and the same port is granted in the same cycle, the new result replaces the old one and `rspk_valid` stays 1.
- **Throughput.** The block completes one ALU operation per cycle in total. A single port can issue every cycle as long as it holds `rspk_ready` high.
- **Invalid op codes.** No checking is done. The ALU's default behaviour (result 0) passes straight through.

## Timing
- **Reset values.** `rsp0_valid = rsp1_valid = 0`, `rsp0_z = rsp1_z = 0`, `prio = 0` (port 0 favoured).
- **During reset.** While `rst = 1`, both `reqk_ready` are 0 and the ALU outputs carry the idle values.
- **Grant path.** `reqk_ready` and the ALU drive are combinational from the `valid`/`ready` inputs and state, in the same cycle.
- **Latency.** The result appears on `rspk_z` with `rspk_valid = 1` exactly one cycle after acceptance.
- **Handshake rules.**
  - A requester must hold op/x/y stable while `valid && !ready`.
  - The arbiter never withdraws `rspk_valid` before `rspk_ready`.
- **Reset mid-operation.** Pending responses are discarded. Requests presented in the reset cycle are not accepted.
- **Back-pressure.** A port whose response is pending with `rspk_ready = 0` is not granted. The other port then gets every cycle, regardless of `prio`.

## Configuration
- Macro: `ALU_ARB_FIXED_PRIO_EN`.
- **Defined:** port 0 always wins contention. The `prio` register is not implemented, and port 1 is granted only when port 0 is not eligible.
- **Undefined (default):** round-robin arbitration as described in Operation.

## Structure
- **Shared package `alu_arb_pkg`:**
  - localparams for ALU op codes: ADD 0000, SUB 0001, SLL 0010, SRL 0011, SRA 0100, SLT 0101, SLTU 0110, XOR 0111, OR 1000, AND 1001, PASSY 1010.
  - `ALU_OP_IDLE = 4'b0000`.
  - a packed `alu_req_t` struct holding op, x and y.
- **Sub-module `alu_arb_rr`:** a two-input grant generator.
  - Inputs: `eligible[1:0]`, `clk`, `rst`.
  - Outputs: `grant[1:0]`.
  - Owns the `prio` register and the `ALU_ARB_FIXED_PRIO_EN` variant.
- **Top level:** the operand multiplexer and the two response registers.

## Test plan
- **Single requester.** Port 0 requests ADD, x=5, y=7 with `rsp0_ready` = 1 → `req0_ready` = 1 in the same cycle; `rsp0_z` = 12 and `rsp0_valid` = 1 one cycle later.
- **Contention.** Both ports valid for 4 cycles, port 0 SUB 10−3 and port 1 XOR 0xF0^0x0F, both responses always ready → grants go 0, 1, 0, 1; results are 7 and 0xFF. With `ALU_ARB_FIXED_PRIO_EN` defined, grants go 0, 0, 0, 0.
- **Back-pressure.** Port 1's response is held with `rsp1_ready` = 0 while both ports request → port 1 is not granted and port 0 is granted every cycle. Releasing `rsp1_ready` lets port 1 be granted in that same cycle.
- **Drain and refill.** Port 0 SLL x=1, y=4 gives 16; next cycle port 0 issues SRA x=0x80000000, y=4 with `rsp0_ready` = 1 → `rsp0_valid` stays 1 and `rsp0_z` becomes 0xF8000000.
- **Reset mid-operation.** `rsp0_valid` = 1 with SLTU result 1 pending, then `rst` asserted for 1 cycle → `rsp0_valid` = 0, `rsp0_z` = 0, both ready signals = 0 during reset, and port 0 is favoured on the first contention after reset.
- **Idle.** No valid requests → ALU op = 0000 with x = y = 0, and the response registers keep their values.
